// File: rtl/hazard_unit_pkg.sv
// Shared types for the MIPS hazard unit: forward-select codes and divide FSM states.
// Optional stall counter enabled by HAZARD_PERF_CNT_EN.
package mips_hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W_BITS = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
  localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Register 0 is hardwired, so it never counts as a dependency.
  function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != REG_W'(0)) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. stall_cnt exists only with HAZARD_PERF_CNT_EN.
interface hazard_unit_if;
  import mips_hazard_pkg::*;

  logic [REG_W-1:0] rsD, rtD, rsE, rtE;
  logic [REG_W-1:0] writeregE, writeregM, writeregW;
  logic             branchD;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             divE, div_done;

  logic                  forwardAD, forwardBD;
  logic [FWD_W_BITS-1:0] forwardAE, forwardBE;
  logic                  stallF, stallD, stallE;
  logic                  flushE, flushM;
  logic                  div_start;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
`endif

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           divE, div_done,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_start
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           divE, div_done,
    output forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_start
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_unit_div_fsm.sv
// Divider handshake FSM: issues div_start and holds divstall until div_done.
module hazard_div_fsm
  import mips_hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic divE,
  input  logic div_done,
  output logic div_start,
  output logic divstall
);

  div_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (divE) state <= BUSY;
        BUSY:    if (div_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // DONE releases the stall so the divide leaves E; no restart on the still-high divE.
  assign div_start = (state == IDLE) && divE;
  assign divstall  = ((state == IDLE) && divE) || (state == BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, stall and flush generation for the five-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cnt counter.
module hazard_unit
  import mips_hazard_pkg::*;
(
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  logic lwstall, branchstall, divstall, frontStall;
  logic divStart;

  hazard_div_fsm u_div_fsm (
    .clk      (clk),
    .rst      (rst),
    .divE     (hz.divE),
    .div_done (hz.div_done),
    .div_start(divStart),
    .divstall (divstall)
  );

  // E-stage operand bypass; M is the younger producer so it wins over W.
  always_comb begin
    hz.forwardAE = FWD_RF;
    hz.forwardBE = FWD_RF;
    if (hz.regwriteM && regMatch(hz.writeregM, hz.rsE))      hz.forwardAE = FWD_M;
    else if (hz.regwriteW && regMatch(hz.writeregW, hz.rsE)) hz.forwardAE = FWD_W;
    if (hz.regwriteM && regMatch(hz.writeregM, hz.rtE))      hz.forwardBE = FWD_M;
    else if (hz.regwriteW && regMatch(hz.writeregW, hz.rtE)) hz.forwardBE = FWD_W;
  end

  assign hz.forwardAD = hz.regwriteM && regMatch(hz.writeregM, hz.rsD);
  assign hz.forwardBD = hz.regwriteM && regMatch(hz.writeregM, hz.rtD);

  assign lwstall = hz.memtoregE &&
                   (regMatch(hz.rtE, hz.rsD) || regMatch(hz.rtE, hz.rtD));

  assign branchstall = hz.branchD &&
      ((hz.regwriteE && (regMatch(hz.writeregE, hz.rsD) || regMatch(hz.writeregE, hz.rtD))) ||
       (hz.memtoregM && (regMatch(hz.writeregM, hz.rsD) || regMatch(hz.writeregM, hz.rtD))));

  assign frontStall   = lwstall || branchstall || divstall;
  assign hz.stallF    = frontStall;
  assign hz.stallD    = frontStall;
  assign hz.stallE    = divstall;
  // A frozen E stage must keep its divide, so the bubble is suppressed.
  assign hz.flushE    = (lwstall || branchstall) && !divstall;
  assign hz.flushM    = divstall;
  assign hz.div_start = divStart;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (frontStall && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (perf-counter steps need HAZARD_PERF_CNT_EN).
module tb_hazard_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_unit_if hif ();

  hazard_unit dut (
    .clk(clk),
    .rst(rst),
    .hz (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
    hif.branchD = 1'b0;
    hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
    hif.memtoregE = 1'b0; hif.memtoregM = 1'b0;
    hif.divE = 1'b0; hif.div_done = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clearIn();
    #2 rst = 1'b0;
    #1;
    chk("rst_stallF", 32'(hif.stallF), 32'd0);
    chk("rst_div_start", 32'(hif.div_start), 32'd0);
    chk("rst_fwdAE", 32'(hif.forwardAE), 32'd0);
    step(); step();
    rst = 1'b1;

    // Forwarding priority and register 0
    step();
    hif.regwriteM = 1'b1; hif.writeregM = 5'd8;
    hif.regwriteW = 1'b1; hif.writeregW = 5'd8; hif.rsE = 5'd8;
    #1 chk("fwdAE_M_prio", 32'(hif.forwardAE), 32'd2);
    step();
    hif.writeregM = 5'd9; hif.rtE = 5'd9;
    #1 chk("fwdAE_W", 32'(hif.forwardAE), 32'd1);
    chk("fwdBE_M", 32'(hif.forwardBE), 32'd2);
    step();
    hif.rsE = 5'd0; hif.rtE = 5'd0; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
    #1 chk("fwdAE_r0", 32'(hif.forwardAE), 32'd0);
    chk("fwdBE_r0", 32'(hif.forwardBE), 32'd0);
    step();
    clearIn();
    hif.regwriteM = 1'b1; hif.writeregM = 5'd3; hif.rtD = 5'd3;
    #1 chk("fwdBD", 32'(hif.forwardBD), 32'd1);
    chk("fwdAD_no", 32'(hif.forwardAD), 32'd0);

    // Load-use
    step();
    clearIn();
    hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
    #1 chk("lw_stallF", 32'(hif.stallF), 32'd1);
    chk("lw_stallD", 32'(hif.stallD), 32'd1);
    chk("lw_flushE", 32'(hif.flushE), 32'd1);
    chk("lw_stallE", 32'(hif.stallE), 32'd0);
    chk("lw_flushM", 32'(hif.flushM), 32'd0);
    step();
    hif.rsD = 5'd6; hif.rtD = 5'd6;
    #1 chk("lw_none_stallF", 32'(hif.stallF), 32'd0);
    chk("lw_none_flushE", 32'(hif.flushE), 32'd0);

    // Branch compare hazards
    step();
    clearIn();
    hif.branchD = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd3; hif.rtD = 5'd3;
    #1 chk("br_E_stallF", 32'(hif.stallF), 32'd1);
    chk("br_E_flushE", 32'(hif.flushE), 32'd1);
    step();
    hif.regwriteE = 1'b0; hif.memtoregM = 1'b1; hif.writeregM = 5'd3; hif.regwriteM = 1'b1;
    #1 chk("br_M_stallD", 32'(hif.stallD), 32'd1);
    chk("br_M_fwdBD", 32'(hif.forwardBD), 32'd1);
    step();
    hif.branchD = 1'b0;
    #1 chk("br_off_stallF", 32'(hif.stallF), 32'd0);

    // Divide, overlapping a load-use hazard in the issue cycle
    step();
    clearIn();
    hif.divE = 1'b1; hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
    #1 chk("div0_start", 32'(hif.div_start), 32'd1);
    chk("div0_stallE", 32'(hif.stallE), 32'd1);
    chk("div0_flushE", 32'(hif.flushE), 32'd0);
    chk("div0_flushM", 32'(hif.flushM), 32'd1);
    step();
    hif.memtoregE = 1'b0; hif.rtE = 5'd0; hif.rsD = 5'd0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      #1 chk($sformatf("div%0d_start", c), 32'(hif.div_start), 32'd0);
      chk($sformatf("div%0d_stallF", c), 32'(hif.stallF), 32'd1);
      chk($sformatf("div%0d_stallE", c), 32'(hif.stallE), 32'd1);
    end
    step();
    hif.div_done = 1'b1;
    #1 chk("div4_stallE", 32'(hif.stallE), 32'd1);
    chk("div4_flushM", 32'(hif.flushM), 32'd1);
    step();
    hif.div_done = 1'b0;
    #1 chk("done_stallF", 32'(hif.stallF), 32'd0);
    chk("done_stallE", 32'(hif.stallE), 32'd0);
    chk("done_flushM", 32'(hif.flushM), 32'd0);
    chk("done_no_restart", 32'(hif.div_start), 32'd0);

    // Back in IDLE a held divE starts a new divide; reset it mid-flight
    step();
    #1 chk("idle_restart", 32'(hif.div_start), 32'd1);
    step();
    step();
    #1 chk("busy2_stallE", 32'(hif.stallE), 32'd1);
    chk("busy2_start", 32'(hif.div_start), 32'd0);
    rst = 1'b0;
    #1 chk("rst_busy_idle_start", 32'(hif.div_start), 32'd1);
    hif.divE = 1'b0;
    #1 chk("rst_busy_stallF", 32'(hif.stallF), 32'd0);
    chk("rst_busy_stallE", 32'(hif.stallE), 32'd0);
    step();
    rst = 1'b1;
    hif.div_done = 1'b1;
    step();
    hif.div_done = 1'b0;
    #1 chk("late_done_stallE", 32'(hif.stallE), 32'd0);
    chk("late_done_start", 32'(hif.div_start), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    // Counter: 2 load-use stall cycles plus a 5-cycle divide
    step();
    clearIn();
    rst = 1'b0;
    #1 chk("cnt_rst", hif.stall_cnt, 32'd0);
    step();
    rst = 1'b1;
    hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
    step(); step();
    clearIn();
    hif.divE = 1'b1;
    step(); step(); step(); step();
    hif.div_done = 1'b1;
    step();
    hif.div_done = 1'b0;
    step();
    hif.divE = 1'b0;
    #1 chk("cnt_seven", hif.stall_cnt, 32'd7);
    step();
    force dut.stallCnt = 32'hFFFF_FFFE;
    #1 release dut.stallCnt;
    hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
    step(); step(); step();
    clearIn();
    #1 chk("cnt_sat", hif.stall_cnt, 32'hFFFF_FFFF);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
